interfaz_alu: RTL and testbench
===============================

// Module: interfaz_alu
// PURPOSE
//  Sequencer between UART RX/TX and the combinational ALU. Collects three bytes from RX
//  (operand A, operand B, opcode), holds them on the ALU inputs, captures the ALU result
//  and hands it to UART TX, then rearms for the next frame. It replaces the manual
//  select_A/select_B/select_op/select_resultado strobes with an autonomous FSM.
// PARAMETERS
//  DATA_WIDTH       8     operand/result width; equals UART byte width
//  OP_WIDTH         6     ALU opcode width; opcode = rx_dato[OP_WIDTH-1:0]
//  TIMEOUT_CYCLES   50000 inter-byte timeout, clock cycles (used only with macro)
// PORTS
//  clock       in   1           system clock, all state on posedge
//  reset       in   1           synchronous, active-high
//  rx_dato     in   DATA_WIDTH  byte from UART RX, valid when rx_done=1
//  rx_done     in   1           one-cycle pulse: new RX byte
//  tx_done     in   1           one-cycle pulse: TX finished current byte
//  alu_result  in   DATA_WIDTH  combinational ALU output
//  dato_A      out  DATA_WIDTH  registered operand A to ALU
//  dato_B      out  DATA_WIDTH  registered operand B to ALU
//  op          out  OP_WIDTH    registered opcode to ALU
//  tx_dato     out  DATA_WIDTH  registered result byte to UART TX
//  tx_start    out  1           one-cycle pulse: start TX of tx_dato
//  timeout_err out  1           one-cycle pulse on frame abort (0 without macro)
// BEHAVIOUR
//  - Reset: state=RECV_A; dato_A, dato_B, op, tx_dato = 0; tx_start=0; timeout_err=0.
//    Reset at any point (mid-frame, during TX wait) aborts the frame; no tx_start issued.
//  - States: RECV_A -> RECV_B -> RECV_OP -> CALC -> WAIT_TX -> RECV_A.
//  - RECV_A/RECV_B/RECV_OP: on posedge with rx_done=1 load dato_A / dato_B /
//    op=rx_dato[OP_WIDTH-1:0] respectively, advance. No rx_done: hold.
//  - CALC: exactly one cycle (ALU settle). On its closing edge tx_dato<=alu_result,
//    tx_start<=1, state->WAIT_TX. Latency: op byte captured at edge N -> tx_start high
//    in cycle after edge N+1; tx_dato stable from then until next CALC.
//  - tx_start: high exactly one cycle, only on CALC->WAIT_TX.
//  - WAIT_TX: on tx_done=1 -> RECV_A. tx_done in any other state ignored.
//  - rx_done during CALC or WAIT_TX: byte dropped, not queued; frame alignment kept.
//  - dato_A/dato_B/op hold their values after the frame until overwritten (ALU output
//    stays valid for debug).
//  - rx_done and tx_done in same cycle in WAIT_TX: go to RECV_A, rx byte dropped.
//  - No arithmetic in this block; widths pass through unchanged.
// CONFIGURATION
//  - Macro INTERFAZ_ALU_TIMEOUT_EN defined: counter clears on every rx_done and on entry
//    to RECV_A; counts while in RECV_B or RECV_OP. On reaching TIMEOUT_CYCLES-1:
//    state->RECV_A, timeout_err pulses one cycle, dato_* keep last values, no tx_start.
//    rx_done on the same edge as expiry wins (byte accepted, no timeout).
//  - Undefined: no counter, partial frame waits forever, timeout_err tied 0.
// STRUCTURE
//  - Package alu_pkg: OP_WIDTH, opcode localparams (ADD=6'b100000, SUB=6'b100010,
//    AND=6'b100100, OR=6'b100101, XOR=6'b100110, SRA=6'b000011, SRL=6'b000010,
//    NOR=6'b100111), FSM state encoding (3-bit localparams).
//  - Sub-module interfaz_timeout (counter + expiry compare), instantiated only under
//    INTERFAZ_ALU_TIMEOUT_EN. FSM and data registers stay in interfaz_alu.
// TESTING (bench instantiates interfaz_alu + alu; RX/TX modelled as pulse drivers)
//  - RX 0x05,0x03,0x20 -> dato_A=0x05,dato_B=0x03,op=0x20; tx_start 1 cycle, tx_dato=0x08.
//  - RX 0x0F,0x03,0x22 then tx_done -> tx_dato=0x0C; next frame 0xF0,0x0F,0x27 -> 0x00.
//  - Extra rx_done 0xAA during WAIT_TX -> dropped; next frame 0x02,0x02,0x20 -> 0x04.
//  - Reset asserted after B byte -> state RECV_A, all outputs 0, no tx_start; new frame OK.
//  - tx_start measured exactly 2 edges after op-byte edge; tx_done withheld 100 cycles
//    -> no second tx_start, state held in WAIT_TX.
//  - With INTERFAZ_ALU_TIMEOUT_EN, TIMEOUT_CYCLES=16: A byte then silence -> timeout_err
//    pulse, no tx_start; following 0x01,0x01,0x20 -> 0x02. Without macro: no abort.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the UART <-> ALU sequencer.
//  OP_WIDTH  : ALU opcode width (opcode = low OP_WIDTH bits of the op byte)
//  OPC_*     : ALU function codes understood by the downstream ALU
//  state_t   : 3-bit sequencer state encoding
package alu_pkg;

  localparam int OP_WIDTH = 6;

  localparam logic [OP_WIDTH-1:0] OPC_ADD = 6'b100000;
  localparam logic [OP_WIDTH-1:0] OPC_SUB = 6'b100010;
  localparam logic [OP_WIDTH-1:0] OPC_AND = 6'b100100;
  localparam logic [OP_WIDTH-1:0] OPC_OR  = 6'b100101;
  localparam logic [OP_WIDTH-1:0] OPC_XOR = 6'b100110;
  localparam logic [OP_WIDTH-1:0] OPC_SRA = 6'b000011;
  localparam logic [OP_WIDTH-1:0] OPC_SRL = 6'b000010;
  localparam logic [OP_WIDTH-1:0] OPC_NOR = 6'b100111;

  typedef enum logic [2:0] {
    RECV_A  = 3'd0,
    RECV_B  = 3'd1,
    RECV_OP = 3'd2,
    CALC    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

endpackage

// File: rtl/interfaz_timeout.sv
// Inter-byte watchdog for a partially received frame.
//  clock    in  system clock
//  reset    in  synchronous, active-high
//  clear    in  restart the count (new byte seen or not mid-frame)
//  count_en in  high while waiting for the 2nd/3rd byte of a frame
//  expired  out high in the cycle the count sits at TIMEOUT_CYCLES-1
module interfaz_timeout #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear)
      cnt <= '0;
    else if (count_en && (cnt != LAST))
      cnt <= cnt + 1'b1;
  end

  assign expired = count_en && (cnt == LAST);

endmodule

// File: rtl/interfaz_alu.sv
// Autonomous sequencer between UART RX/TX and a combinational ALU.
// Receives A, B and opcode bytes, holds them on the ALU inputs, captures the
// result one cycle later and pulses tx_start; rearms on tx_done.
//  clock, reset          clock and synchronous active-high reset
//  rx_dato/rx_done       received byte and its one-cycle valid pulse
//  tx_done               one-cycle pulse, TX finished the current byte
//  alu_result            combinational ALU output
//  dato_A/dato_B/op      registered ALU operands and opcode
//  tx_dato/tx_start      registered result byte and one-cycle start pulse
//  timeout_err           one-cycle pulse when a partial frame is aborted
// Optional macro INTERFAZ_ALU_TIMEOUT_EN enables the inter-byte timeout.
module interfaz_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int OP_WIDTH       = alu_pkg::OP_WIDTH,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_dato,
  input  logic                  rx_done,
  input  logic                  tx_done,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [DATA_WIDTH-1:0] dato_A,
  output logic [DATA_WIDTH-1:0] dato_B,
  output logic [OP_WIDTH-1:0]   op,
  output logic [DATA_WIDTH-1:0] tx_dato,
  output logic                  tx_start,
  output logic                  timeout_err
);

  state_t state;
  logic   expired;

`ifdef INTERFAZ_ALU_TIMEOUT_EN
  interfaz_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear    (rx_done || !((state == RECV_B) || (state == RECV_OP))),
    .count_en ((state == RECV_B) || (state == RECV_OP)),
    .expired  (expired)
  );
`else
  // No watchdog: a partial frame waits forever. The compare only keeps the
  // parameter referenced; it is never true.
  assign expired = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RECV_A;
      dato_A      <= '0;
      dato_B      <= '0;
      op          <= '0;
      tx_dato     <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        RECV_A:
          if (rx_done) begin
            dato_A <= rx_dato;
            state  <= RECV_B;
          end
        // A byte arriving on the expiry edge wins over the timeout.
        RECV_B:
          if (rx_done) begin
            dato_B <= rx_dato;
            state  <= RECV_OP;
          end else if (expired) begin
            timeout_err <= 1'b1;
            state       <= RECV_A;
          end
        RECV_OP:
          if (rx_done) begin
            op    <= rx_dato[OP_WIDTH-1:0];
            state <= CALC;
          end else if (expired) begin
            timeout_err <= 1'b1;
            state       <= RECV_A;
          end
        // One cycle for the ALU to settle on the new operands.
        CALC: begin
          tx_dato  <= alu_result;
          tx_start <= 1'b1;
          state    <= WAIT_TX;
        end
        // rx bytes here are dropped; frame alignment restarts at RECV_A.
        WAIT_TX:
          if (tx_done)
            state <= RECV_A;
        default:
          state <= RECV_A;
      endcase
    end
  end

endmodule

// File: tb/tb_interfaz_alu.sv
module tb_interfaz_alu;
  import alu_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rx_dato;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] alu_result;
  logic [7:0] dato_A, dato_B, tx_dato;
  logic [5:0] op;
  logic       tx_start, timeout_err;

  int vectors = 0;
  int miscompares = 0;
  int n_tx = 0;
  int n_to = 0;
  logic prev_tx = 1'b0;
  logic [7:0] sb[$];

  always #5 clock = ~clock;

  interfaz_alu #(
    .DATA_WIDTH(8), .OP_WIDTH(6), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset), .rx_dato(rx_dato), .rx_done(rx_done),
    .tx_done(tx_done), .alu_result(alu_result), .dato_A(dato_A),
    .dato_B(dato_B), .op(op), .tx_dato(tx_dato), .tx_start(tx_start),
    .timeout_err(timeout_err)
  );

  // Behavioural stand-in for the downstream combinational ALU.
  always_comb begin
    alu_result = 8'h00;
    case (op)
      OPC_ADD: alu_result = dato_A + dato_B;
      OPC_SUB: alu_result = dato_A - dato_B;
      OPC_AND: alu_result = dato_A & dato_B;
      OPC_OR:  alu_result = dato_A | dato_B;
      OPC_XOR: alu_result = dato_A ^ dato_B;
      OPC_SRA: alu_result = $unsigned($signed(dato_A) >>> dato_B);
      OPC_SRL: alu_result = dato_A >> dato_B;
      OPC_NOR: alu_result = ~(dato_A | dato_B);
      default: alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard side: every tx_start pops one expected result.
  always @(negedge clock) begin
    if (tx_start) begin
      n_tx++;
      if (sb.size() == 0) chk("spurious_tx_start", 1, 0);
      else chk("tx_dato", {24'h0, tx_dato}, {24'h0, sb.pop_front()});
      if (prev_tx) chk("tx_start_width", 2, 1);
    end
    if (timeout_err) n_to++;
    prev_tx = tx_start;
  end

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    rx_dato = b; rx_done = 1'b1;
    @(negedge clock);
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(negedge clock); tx_done = 1'b1;
    @(negedge clock); tx_done = 1'b0;
  endtask

  // Full frame; tx_start must appear exactly two edges after the op edge.
  task automatic frame(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] o, input logic [7:0] e);
    send(a);
    send(b);
    sb.push_back(e);
    send(o);
    chk("tx_start_early", {31'h0, tx_start}, 0);
    @(negedge clock);
    chk("tx_start_latency", {31'h0, tx_start}, 1);
    chk("dato_A", {24'h0, dato_A}, {24'h0, a});
    chk("dato_B", {24'h0, dato_B}, {24'h0, b});
    chk("op", {26'h0, op}, {26'h0, o[5:0]});
    @(negedge clock);
    chk("tx_start_one_cycle", {31'h0, tx_start}, 0);
  endtask

  initial begin
    int t0;
    reset = 1'b1; rx_dato = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_dato_A", {24'h0, dato_A}, 0);
    chk("rst_tx_dato", {24'h0, tx_dato}, 0);
    chk("rst_tx_start", {31'h0, tx_start}, 0);
    chk("rst_timeout_err", {31'h0, timeout_err}, 0);

    frame(8'h05, 8'h03, 8'h20, 8'h08);
    pulse_tx_done();
    frame(8'h0F, 8'h03, 8'h22, 8'h0C);
    pulse_tx_done();
    frame(8'hF0, 8'h0F, 8'h27, 8'h00);

    // Stray byte while waiting for TX is dropped.
    send(8'hAA);
    chk("drop_in_wait_tx", {24'h0, dato_A}, 32'hF0);
    pulse_tx_done();
    frame(8'h02, 8'h02, 8'h20, 8'h04);

    // tx_done withheld: no second start, still in WAIT_TX (bytes dropped).
    t0 = n_tx;
    repeat (100) @(negedge clock);
    send(8'h77);
    chk("no_second_tx_start", n_tx - t0, 0);
    chk("held_wait_tx", {24'h0, dato_A}, 32'h02);

    // rx_done and tx_done together in WAIT_TX: leave, byte dropped.
    @(negedge clock);
    rx_dato = 8'h99; rx_done = 1'b1; tx_done = 1'b1;
    @(negedge clock);
    rx_done = 1'b0; tx_done = 1'b0;
    chk("rx_tx_same_cycle", {24'h0, dato_A}, 32'h02);
    frame(8'hF0, 8'h3C, 8'h24, 8'h30);
    pulse_tx_done();
    frame(8'h50, 8'h05, 8'h25, 8'h55);
    pulse_tx_done();
    frame(8'hFF, 8'h0F, 8'h26, 8'hF0);
    pulse_tx_done();
    frame(8'h80, 8'h02, 8'h02, 8'h20);
    pulse_tx_done();
    frame(8'h80, 8'h02, 8'h03, 8'hE0);
    pulse_tx_done();

    // Reset after B byte aborts the frame.
    t0 = n_tx;
    send(8'h11);
    send(8'h22);
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    chk("mid_rst_dato_A", {24'h0, dato_A}, 0);
    chk("mid_rst_dato_B", {24'h0, dato_B}, 0);
    chk("mid_rst_op", {26'h0, op}, 0);
    chk("mid_rst_tx_dato", {24'h0, tx_dato}, 0);
    repeat (4) @(negedge clock);
    chk("mid_rst_no_tx", n_tx - t0, 0);
    frame(8'h05, 8'h03, 8'h20, 8'h08);
    pulse_tx_done();

    // A byte then silence.
    t0 = n_tx;
    send(8'h01);
    repeat (40) @(negedge clock);
`ifdef INTERFAZ_ALU_TIMEOUT_EN
    chk("timeout_pulses", n_to, 1);
    chk("timeout_no_tx", n_tx - t0, 0);
    frame(8'h01, 8'h01, 8'h20, 8'h02);
`else
    chk("no_timeout_pulse", n_to, 0);
    chk("no_abort_dato_A", {24'h0, dato_A}, 32'h01);
    send(8'h01);
    sb.push_back(8'h02);
    send(8'h20);
    @(negedge clock);
    chk("late_frame_tx_start", {31'h0, tx_start}, 1);
`endif
    pulse_tx_done();
    repeat (3) @(negedge clock);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
